// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the RV32I core
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state_e;
endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register with load/bubble/hold control
// Ports: clk, rst (async active-low); load captures fetch_*; bubble writes NOP
// and clears valid while keeping pc/pc_plus4; neither holds. load wins over bubble.
module if_id_register
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] fetch_instr,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] fetch_pc_plus4,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      instr    <= NOP;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= fetch_instr;
      pc       <= fetch_pc;
      pc_plus4 <= fetch_pc_plus4;
      valid    <= 1'b1;
    end else if (bubble) begin
      instr    <= NOP;
      valid    <= 1'b0;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage with req/ready imem handshake and IF/ID register
// Ports: clk, rst (async active-low); PCSrcE/PCTargetE redirect from Execute;
// StallD/FlushD from hazard unit; imem_req/imem_addr/imem_rdata/imem_ready to
// instruction memory; InstrD/PCD/PCPlus4D/ValidD to Decode.
module fetch_stage #(
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC  = 32'h00000000,
  parameter logic [riscv_pkg::XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         PCSrcE,
  input  logic [riscv_pkg::XLEN-1:0]   PCTargetE,
  input  logic                         StallD,
  input  logic                         FlushD,
  output logic                         imem_req,
  output logic [riscv_pkg::XLEN-1:0]   imem_addr,
  input  logic [riscv_pkg::XLEN-1:0]   imem_rdata,
  input  logic                         imem_ready,
  output logic [riscv_pkg::XLEN-1:0]   InstrD,
  output logic [riscv_pkg::XLEN-1:0]   PCD,
  output logic [riscv_pkg::XLEN-1:0]   PCPlus4D,
  output logic                         ValidD
);
  import riscv_pkg::*;
  fetch_state_e state, state_next;
  logic [XLEN-1:0] pcf, pcf_next, skid, redir, target;
  logic started, fire, load, bubble, skid_load;
  assign target    = PCTargetE & ~32'h3;
  // started keeps the request low for the first cycle out of reset
  assign imem_req  = started && state != HOLD;
  assign imem_addr = pcf;
  assign fire      = imem_req && imem_ready;
  always_comb begin
    state_next = state;
    pcf_next   = pcf;
    load       = 1'b0;
    bubble     = 1'b0;
    skid_load  = 1'b0;
    case (state)
      FETCH: begin
        bubble = !StallD || PCSrcE || FlushD;
        if (PCSrcE) begin
          // an unanswered request must stay on the bus, so park the target
          if (imem_req && !imem_ready) state_next = DROP;
          else pcf_next = target;
        end else if (!FlushD && fire) begin
          if (StallD) begin
            skid_load  = 1'b1;
            state_next = HOLD;
          end else begin
            load     = 1'b1;
            pcf_next = pcf + 32'd4;
          end
        end
      end
      HOLD: begin
        bubble = PCSrcE || FlushD;
        if (PCSrcE) begin
          pcf_next   = target;
          state_next = FETCH;
        end else if (FlushD) begin
          state_next = FETCH;
        end else if (!StallD) begin
          load       = 1'b1;
          pcf_next   = pcf + 32'd4;
          state_next = FETCH;
        end
      end
      DROP: begin
        bubble = !StallD || PCSrcE || FlushD;
        if (imem_ready) begin
          pcf_next   = PCSrcE ? target : redir;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= FETCH;
      pcf     <= RESET_PC;
      skid    <= '0;
      redir   <= '0;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      pcf     <= pcf_next;
      started <= 1'b1;
      if (skid_load) skid <= imem_rdata;
      if (PCSrcE) redir <= target;
    end
  if_id_register #(.NOP(NOP_INSTR)) u_if_id (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .bubble        (bubble),
    .fetch_instr   (state == HOLD ? skid : imem_rdata),
    .fetch_pc      (pcf),
    .fetch_pc_plus4(pcf + 32'd4),
    .instr         (InstrD),
    .pc            (PCD),
    .pc_plus4      (PCPlus4D),
    .valid         (ValidD)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;
  logic clk = 1'b0, rst = 1'b0;
  logic PCSrcE = 1'b0, StallD = 1'b0, FlushD = 1'b0, imem_ready = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic imem_req, ValidD;
  logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  int n_vec = 0, n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hA4A4A4A4;
    if (a == 32'h4) return 32'h00500093;
    return {a[15:0], 16'h0093} ^ 32'h00A00000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallD(StallD), .FlushD(FlushD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks the fetch PC, a word captured while Decode is
  // stalled, and a response owed to memory that must be thrown away.
  logic        m_live = 0, m_have = 0, m_discard = 0, e_valid = 0;
  logic [31:0] m_pc = 0, m_word = 0, m_redir = 0;
  logic [31:0] e_instr = 32'h13, e_pc = 0, e_pc4 = 0;

  task automatic m_bubble();
    e_instr = 32'h13;
    e_valid = 1'b0;
  endtask

  task automatic m_deliver(input logic [31:0] w);
    e_instr = w;
    e_pc    = m_pc;
    e_pc4   = m_pc + 32'd4;
    e_valid = 1'b1;
    m_pc    = m_pc + 32'd4;
  endtask

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_live = 0; m_have = 0; m_discard = 0; m_pc = 0; m_word = 0; m_redir = 0;
      e_instr = 32'h13; e_pc = 0; e_pc4 = 0; e_valid = 0;
    end else begin
      logic out, tgt;
      logic [31:0] t;
      out = m_live && !m_have;
      t = PCTargetE & ~32'h3;
      tgt = PCSrcE;
      if (tgt) begin
        m_bubble();
        m_have = 0;
        if (out && !imem_ready) begin m_discard = 1; m_redir = t; end
        else begin m_pc = t; m_discard = 0; end
      end else if (m_discard) begin
        if (!StallD || FlushD) m_bubble();
        if (imem_ready) begin m_pc = m_redir; m_discard = 0; end
      end else if (FlushD) begin
        m_bubble();
        m_have = 0;
      end else if (m_have) begin
        if (!StallD) begin m_deliver(m_word); m_have = 0; end
      end else if (out && imem_ready) begin
        if (StallD) begin m_word = mem_word(m_pc); m_have = 1; end
        else m_deliver(mem_word(m_pc));
      end else if (!StallD) m_bubble();
      m_live = 1;
    end

  always @(negedge clk)
    if (chk_en) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_live && !m_have});
      if (m_live && !m_have) chk("imem_addr", imem_addr, m_pc);
      chk("InstrD", InstrD, e_instr);
      chk("PCD", PCD, e_pc);
      chk("PCPlus4D", PCPlus4D, e_pc4);
      chk("ValidD", {31'b0, ValidD}, {31'b0, e_valid});
    end

  task automatic cyc(input logic r, input logic st, input logic fl, input logic ps, input logic [31:0] tg);
    imem_ready = r; StallD = st; FlushD = fl; PCSrcE = ps; PCTargetE = tg;
    @(negedge clk); #1;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_instr", InstrD, 32'h00000013);
    chk("rst_valid", {31'b0, ValidD}, 32'h0);
    rst = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    cyc(1, 0, 0, 0, 0);
    chk("w0_instr", InstrD, 32'hA4A4A4A4);
    chk("w0_pc", PCD, 32'h0);
    chk("w0_pc4", PCPlus4D, 32'h4);
    cyc(1, 0, 0, 0, 0);
    chk("w1_instr", InstrD, 32'h00500093);
    chk("w1_pc4", PCPlus4D, 32'h8);
    chk("w1_valid", {31'b0, ValidD}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_valid", {31'b0, ValidD}, 32'h0);
    end
    cyc(1, 0, 0, 0, 0);
    chk("w2_pc", PCD, 32'h8);
    cyc(1, 1, 0, 0, 0);
    chk("hold_req", {31'b0, imem_req}, 32'h0);
    chk("hold_pc", PCD, 32'h8);
    cyc(1, 1, 0, 0, 0);
    chk("hold2_pc", PCD, 32'h8);
    cyc(1, 0, 0, 0, 0);
    chk("unhold_pc", PCD, 32'hC);
    chk("unhold_instr", InstrD, mem_word(32'hC));
    cyc(0, 0, 0, 1, 32'h40);
    chk("drop_instr", InstrD, 32'h00000013);
    chk("drop_addr", imem_addr, 32'h10);
    cyc(0, 0, 0, 0, 0);
    chk("drop2_addr", imem_addr, 32'h10);
    cyc(1, 0, 0, 0, 0);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_valid", {31'b0, ValidD}, 32'h0);
    cyc(1, 0, 0, 0, 0);
    chk("w40_pc", PCD, 32'h40);
    cyc(1, 0, 0, 1, 32'hFFFFFFFF);
    chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
    cyc(1, 0, 0, 0, 0);
    chk("wrap_pc", PCD, 32'hFFFFFFFC);
    chk("wrap_pc4", PCPlus4D, 32'h0);
    chk("wrap_next", imem_addr, 32'h0);
    cyc(1, 0, 1, 0, 0);
    chk("flush_addr", imem_addr, 32'h0);
    chk("flush_valid", {31'b0, ValidD}, 32'h0);
    cyc(1, 0, 0, 0, 0);
    chk("refetch_instr", InstrD, 32'hA4A4A4A4);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0, {24'h0, 8'($urandom_range(0, 255))});
    cyc(0, 0, 0, 1, 32'h80);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
    chk("mid_rst_instr", InstrD, 32'h00000013);
    chk("mid_rst_pc", PCD, 32'h0);
    chk("mid_rst_pc4", PCPlus4D, 32'h0);
    chk("mid_rst_valid", {31'b0, ValidD}, 32'h0);
    cyc(1, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_req", {31'b0, imem_req}, 32'h1);
    cyc(1, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
